// File: rtl/cuckoo_loader_pkg.sv
// Shared widths, FSM encoding, done codes and the bucket hash for the cuckoo table loader.
package cuckoo_loader_pkg;

    localparam int IDX_AW = 10;
    localparam int PTR_W  = 9;
    localparam int PAT_W  = 90;
    localparam int OCC_AW = IDX_AW + 1;
    localparam int CNT_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        RD,
        DECIDE,
        WR_PAT,
        WR_IDX,
        DONE,
        CLEAR
    } state_t;

    localparam logic [1:0] DS_T1    = 2'b00;
    localparam logic [1:0] DS_T2    = 2'b01;
    localparam logic [1:0] DS_COLL  = 2'b10;
    localparam logic [1:0] DS_CLEAR = 2'b11;

    function automatic logic [IDX_AW-1:0] cuckoo_hash(input logic [IDX_AW-1:0] p,
                                                      input logic [7:0] b);
        logic [IDX_AW-1:0] sum;
        sum = {p[6:0], 3'b000} + {3'b000, p[9:3]} + {2'b00, b};
        return sum ^ p;
    endfunction

endpackage

// File: rtl/cuckoo_occ_ram.sv
// 2048x1 occupancy bitmap: synchronous read (1-cycle latency), one write port, no reset.
// No backpressure; the owner sequences reads and writes so they never target the same cycle.
module cuckoo_occ_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_din
);

    logic mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_din;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cuckoo_loader.sv
// Inserts one key into a two-table cuckoo index (pattern write, then index write) or clears both tables.
// Insert: done 6 cycles after accept (4 on collision); clear: 2048 cycles; cmd_ready low whenever busy.
module cuckoo_loader
    import cuckoo_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_AW-1:0] cmd_prehash1,
    input  logic [IDX_AW-1:0] cmd_prehash2,
    input  logic [7:0]        cmd_byte,
    input  logic [PTR_W-1:0]  cmd_ptr,
    input  logic [PAT_W-1:0]  cmd_data,
    output logic              idx_we,
    output logic [OCC_AW-1:0] idx_addr,
    output logic [PTR_W-1:0]  idx_din,
    output logic              pat_we,
    output logic [PTR_W-1:0]  pat_addr,
    output logic [PAT_W-1:0]  pat_din,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic [1:0]        done_status,
    output logic [CNT_W-1:0]  occ_count
);

    state_t              state_q, state_d;
    logic [OCC_AW-1:0]   clr_cnt;
    logic                clr_pend;
    logic [1:0]          status_q;

    logic [IDX_AW-1:0]   p1_q, p2_q, a1_q, a2_q;
    logic [7:0]          byte_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PAT_W-1:0]    data_q;
    logic [OCC_AW-1:0]   target_q;
    logic                occ1_q;

    logic [OCC_AW-1:0]   occ_rd_addr;
    logic                occ_rd_data;
    logic                occ_we;
    logic [OCC_AW-1:0]   occ_wr_addr;
    logic                occ_wr_din;

    cuckoo_occ_ram #(.AW(OCC_AW)) u_occ (
        .clk     (clk),
        .rd_addr (occ_rd_addr),
        .rd_data (occ_rd_data),
        .we      (occ_we),
        .wr_addr (occ_wr_addr),
        .wr_din  (occ_wr_din)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        idx_we      = 1'b0;
        idx_addr    = '0;
        idx_din     = '0;
        pat_we      = 1'b0;
        pat_addr    = '0;
        pat_din     = '0;
        done        = 1'b0;
        done_status = 2'b00;
        busy        = (state_q != IDLE);
        occ_rd_addr = '0;
        occ_we      = 1'b0;
        occ_wr_addr = '0;
        occ_wr_din  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = !clr_pend && !clr_req;
                if (clr_req || clr_pend) begin
                    state_d = CLEAR;
                end else if (cmd_valid) begin
                    state_d = HASH;
                end
            end
            // T1 is read a cycle early from the captured fields so both bits are ready in DECIDE.
            HASH: begin
                occ_rd_addr = {1'b0, cuckoo_hash(p1_q, byte_q)};
                state_d     = RD;
            end
            RD: begin
                occ_rd_addr = {1'b1, a2_q};
                state_d     = DECIDE;
            end
            DECIDE: begin
                if (!occ1_q || !occ_rd_data) begin
                    state_d = WR_PAT;
                end else begin
                    state_d = DONE;
                end
            end
            WR_PAT: begin
                pat_we   = 1'b1;
                pat_addr = ptr_q;
                pat_din  = data_q;
                state_d  = WR_IDX;
            end
            WR_IDX: begin
                idx_we      = 1'b1;
                idx_addr    = target_q;
                idx_din     = ptr_q;
                occ_we      = 1'b1;
                occ_wr_addr = target_q;
                occ_wr_din  = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                done        = 1'b1;
                done_status = status_q;
                state_d     = (clr_pend || clr_req) ? CLEAR : IDLE;
            end
            CLEAR: begin
                idx_we      = 1'b1;
                idx_addr    = clr_cnt;
                occ_we      = 1'b1;
                occ_wr_addr = clr_cnt;
                if (&clr_cnt) begin
                    state_d = DONE;
                end
            end
            default: state_d = CLEAR;
        endcase

        // Nothing leaves the block while reset is held, whatever state it was caught in.
        if (rst) begin
            cmd_ready   = 1'b0;
            idx_we      = 1'b0;
            idx_addr    = '0;
            pat_we      = 1'b0;
            pat_addr    = '0;
            pat_din     = '0;
            idx_din     = '0;
            done        = 1'b0;
            done_status = 2'b00;
            occ_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt   <= '0;
            clr_pend  <= 1'b0;
            occ_count <= '0;
            status_q  <= DS_CLEAR;
        end else begin
            state_q <= state_d;

            if (state_d == CLEAR) begin
                clr_pend <= 1'b0;
            end else if (clr_req && state_q != IDLE && state_q != CLEAR) begin
                clr_pend <= 1'b1;
            end

            if (state_q == DECIDE) begin
                if (!occ1_q) begin
                    status_q <= DS_T1;
                end else if (!occ_rd_data) begin
                    status_q <= DS_T2;
                end else begin
                    status_q <= DS_COLL;
                end
            end

            if (state_q == WR_IDX) begin
                occ_count <= occ_count + 12'd1;
            end

            if (state_q == CLEAR) begin
                clr_cnt   <= clr_cnt + 11'd1;
                occ_count <= '0;
                if (&clr_cnt) begin
                    status_q <= DS_CLEAR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && cmd_ready && cmd_valid) begin
            p1_q   <= cmd_prehash1;
            p2_q   <= cmd_prehash2;
            byte_q <= cmd_byte;
            ptr_q  <= cmd_ptr;
            data_q <= cmd_data;
        end
        if (state_q == HASH) begin
            a1_q <= cuckoo_hash(p1_q, byte_q);
            a2_q <= cuckoo_hash(p2_q, byte_q);
        end
        if (state_q == RD) begin
            occ1_q <= occ_rd_data;
        end
        if (state_q == DECIDE) begin
            target_q <= !occ1_q ? {1'b0, a1_q} : {1'b1, a2_q};
        end
    end

endmodule
